// File: rtl/song_pkg.sv
// ----------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song sequencer:
//   - state_t        : sequencer FSM states
//   - note constants : half-period in clock cycles at 100 MHz (SP = rest)
//   - dur constants  : note length in duration units (1 unit = 1/8 s default)
//   - note_t         : one song-table entry (period, duration)
//   - cnt_width()    : counter width for a modulus, never below 1 bit
//   - demo_note()    : small reference tune usable by a song-table module
// ----------------------------------------------------------------------------
package song_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    localparam int NOTE_PERIOD_W = 20;
    localparam int NOTE_DUR_W    = 5;

    // Half-periods in clock cycles for a 100 MHz system clock.
    localparam logic [NOTE_PERIOD_W-1:0] C4 = 20'd191110;
    localparam logic [NOTE_PERIOD_W-1:0] D4 = 20'd170265;
    localparam logic [NOTE_PERIOD_W-1:0] E4 = 20'd151685;
    localparam logic [NOTE_PERIOD_W-1:0] F4 = 20'd143172;
    localparam logic [NOTE_PERIOD_W-1:0] G4 = 20'd127551;
    localparam logic [NOTE_PERIOD_W-1:0] C5 = 20'd95556;
    localparam logic [NOTE_PERIOD_W-1:0] SP = 20'd0;

    // Durations in units.
    localparam logic [NOTE_DUR_W-1:0] EIGHTH  = 5'd1;
    localparam logic [NOTE_DUR_W-1:0] QUARTER = 5'd2;
    localparam logic [NOTE_DUR_W-1:0] HALF    = 5'd4;
    localparam logic [NOTE_DUR_W-1:0] ONE     = 5'd8;
    localparam logic [NOTE_DUR_W-1:0] TWO     = 5'd16;

    typedef struct packed {
        logic [NOTE_PERIOD_W-1:0] period;
        logic [NOTE_DUR_W-1:0]    dur;
    } note_t;

    // Width of a counter that must hold 0 .. n-1; a modulus of 1 still
    // needs one bit so the counter declaration stays legal.
    function automatic int cnt_width(input int unsigned n);
        int w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    // Short reference tune; any index past the tune returns the
    // end-of-song marker (dur = 0).
    function automatic note_t demo_note(input int unsigned idx);
        note_t n;
        case (idx)
            32'd0:   n = '{period: C4, dur: QUARTER};
            32'd1:   n = '{period: D4, dur: QUARTER};
            32'd2:   n = '{period: E4, dur: QUARTER};
            32'd3:   n = '{period: F4, dur: EIGHTH};
            32'd4:   n = '{period: SP, dur: EIGHTH};
            32'd5:   n = '{period: G4, dur: HALF};
            32'd6:   n = '{period: C5, dur: ONE};
            32'd7:   n = '{period: SP, dur: TWO};
            default: n = '{period: SP, dur: 5'd0};
        endcase
        return n;
    endfunction

endpackage

// File: rtl/song_sequencer_tone_gen.sv
// ----------------------------------------------------------------------------
// tone_gen
// Square-wave generator driven by a half-period count.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   period       : half-period in clock cycles, 0 = rest (output held low)
//   enable       : advance the half-period counter this cycle
//   clear        : restart the tone phase (counter and output to 0)
//   audio_out    : registered square-wave output
// clear has priority over enable; with neither asserted everything holds,
// which is how pause freezes the waveform.
// ----------------------------------------------------------------------------
module tone_gen
    import song_pkg::*;
#(
    parameter int PERIOD_W = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                enable,
    input  logic                clear,
    output logic                audio_out
);

    logic [PERIOD_W-1:0] half_cnt_r;
    logic                is_rest_s;
    logic                half_done_s;

    // Detect the last cycle of the current half-period; a rest never wraps.
    always_comb begin
        is_rest_s   = (period == {PERIOD_W{1'b0}});
        half_done_s = 1'b0;
        if (is_rest_s) begin
            half_done_s = 1'b0;
        end else begin
            half_done_s = (half_cnt_r == (period - {{(PERIOD_W-1){1'b0}}, 1'b1}));
        end
    end

    // Half-period counter and output toggle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_cnt_r <= {PERIOD_W{1'b0}};
            audio_out  <= 1'b0;
        end else if (clear) begin
            half_cnt_r <= {PERIOD_W{1'b0}};
            audio_out  <= 1'b0;
        end else if (enable) begin
            if (is_rest_s) begin
                half_cnt_r <= {PERIOD_W{1'b0}};
                audio_out  <= 1'b0;
            end else if (half_done_s) begin
                half_cnt_r <= {PERIOD_W{1'b0}};
                audio_out  <= ~audio_out;
            end else begin
                half_cnt_r <= half_cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// ----------------------------------------------------------------------------
// song_sequencer
// Plays a song from an external (period, duration) table as a square wave.
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   start, stop         : 1-cycle control pulses (stop > start)
//   pause               : level, freezes playback while high in PLAY
//   loop_en             : level, sampled at song end to restart the song
//   rom_addr            : table index being fetched (registered)
//   rom_period, rom_dur : table data, valid one cycle after rom_addr
//   audio_out           : square-wave output
//   aud_sd              : amplifier enable, always 1
//   busy                : high whenever not IDLE
//   done                : 1-cycle pulse on song completion
//   note_idx            : index of the current note
// Each note takes FETCH + LOAD + dur*UNIT_CYCLES PLAY cycles. rom_addr is
// updated together with note_idx, so it is already stable during FETCH and
// a 1-cycle registered table presents its data in LOAD.
// ----------------------------------------------------------------------------
module song_sequencer
    import song_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int UNIT_CYCLES = CLK_HZ / 8,
    parameter int SONG_LEN    = 48,
    parameter int ADDR_W      = 10,
    parameter int PERIOD_W    = 20,
    parameter int DUR_W       = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PERIOD_W-1:0] rom_period,
    input  logic [DUR_W-1:0]    rom_dur,
    output logic                audio_out,
    output logic                aud_sd,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   note_idx
);

    localparam int                UNIT_W    = cnt_width(UNIT_CYCLES);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SONG_LEN - 1);

    state_t              state_r;
    logic [PERIOD_W-1:0] period_r;
    logic [DUR_W-1:0]    dur_cnt_r;
    logic [UNIT_W-1:0]   unit_cnt_r;

    logic play_step_s;
    logic unit_last_s;
    logic note_last_s;
    logic end_path_s;
    logic tone_enable_s;
    logic tone_clear_s;

    assign aud_sd = 1'b1;

    // Per-cycle decisions. start/stop override everything, so a playing
    // step only happens in an unpaused PLAY cycle without a control pulse.
    always_comb begin
        play_step_s = (state_r == PLAY) && !pause && !stop && !start;
        unit_last_s = (unit_cnt_r == UNIT_LAST);
        note_last_s = play_step_s && unit_last_s &&
                      (dur_cnt_r == {{(DUR_W-1){1'b0}}, 1'b1});
        end_path_s  = 1'b0;
        if (stop || start) begin
            end_path_s = 1'b0;
        end else if ((state_r == LOAD) && (rom_dur == {DUR_W{1'b0}})) begin
            end_path_s = 1'b1;
        end else begin
            end_path_s = note_last_s && (note_idx == LAST_IDX);
        end
        // The tone only runs while the next cycle is still PLAY; leaving
        // PLAY (or sitting in any other state) restarts the phase at 0.
        tone_enable_s = play_step_s && !note_last_s;
        tone_clear_s  = (state_r != PLAY) || stop || start || note_last_s;
    end

    // Sequencer FSM with its counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            period_r   <= {PERIOD_W{1'b0}};
            dur_cnt_r  <= {DUR_W{1'b0}};
            unit_cnt_r <= {UNIT_W{1'b0}};
            note_idx   <= {ADDR_W{1'b0}};
            rom_addr   <= {ADDR_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state_r <= IDLE;
                busy    <= 1'b0;
            end else if (start) begin
                state_r  <= FETCH;
                busy     <= 1'b1;
                note_idx <= {ADDR_W{1'b0}};
                rom_addr <= {ADDR_W{1'b0}};
            end else if (end_path_s) begin
                done     <= 1'b1;
                note_idx <= {ADDR_W{1'b0}};
                rom_addr <= {ADDR_W{1'b0}};
                if (loop_en) begin
                    state_r <= FETCH;
                    busy    <= 1'b1;
                end else begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    FETCH: begin
                        rom_addr <= note_idx;
                        state_r  <= LOAD;
                    end
                    LOAD: begin
                        period_r   <= rom_period;
                        dur_cnt_r  <= rom_dur;
                        unit_cnt_r <= {UNIT_W{1'b0}};
                        state_r    <= PLAY;
                    end
                    PLAY: begin
                        if (play_step_s) begin
                            if (unit_last_s) begin
                                unit_cnt_r <= {UNIT_W{1'b0}};
                                dur_cnt_r  <= dur_cnt_r - {{(DUR_W-1){1'b0}}, 1'b1};
                            end else begin
                                unit_cnt_r <= unit_cnt_r + {{(UNIT_W-1){1'b0}}, 1'b1};
                            end
                            if (note_last_s) begin
                                note_idx <= note_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                                rom_addr <= note_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                                state_r  <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clock     (clock),
        .reset     (reset),
        .period    (period_r),
        .enable    (tone_enable_s),
        .clear     (tone_clear_s),
        .audio_out (audio_out)
    );

endmodule

// File: tb/tb_song_sequencer.sv
// ----------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench: a note-position model (cycles into the current note)
// predicts every output each cycle, and directed scenarios pin the model with
// hand-computed cycle numbers. The song table is modelled as a 1-cycle
// registered ROM.
// ----------------------------------------------------------------------------
module tb_song_sequencer;

    localparam int UC = 4;
    localparam int SL = 3;
    localparam int AW = 4;
    localparam int PW = 8;
    localparam int DW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] rom_period;
    logic [DW-1:0] rom_dur;
    logic          audio_out;
    logic          aud_sd;
    logic          busy;
    logic          done;
    logic [AW-1:0] note_idx;

    logic [PW-1:0] tbl_p [0:15];
    logic [DW-1:0] tbl_d [0:15];

    int n_checks = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // model state
    bit m_active = 1'b0;
    int m_idx = 0;
    int m_pos = 0;
    int m_per = 0;
    int m_dur = 0;
    bit m_done = 1'b0;

    song_sequencer #(
        .CLK_HZ      (32),
        .UNIT_CYCLES (UC),
        .SONG_LEN    (SL),
        .ADDR_W      (AW),
        .PERIOD_W    (PW),
        .DUR_W       (DW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop_en    (loop_en),
        .rom_addr   (rom_addr),
        .rom_period (rom_period),
        .rom_dur    (rom_dur),
        .audio_out  (audio_out),
        .aud_sd     (aud_sd),
        .busy       (busy),
        .done       (done),
        .note_idx   (note_idx)
    );

    always #5 clock = ~clock;

    // registered song table
    always @(posedge clock) begin
        rom_period <= tbl_p[rom_addr];
        rom_dur    <= tbl_d[rom_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge. m_pos counts cycles into the
    // current note: 0 = fetch, 1 = load, 2.. = playing (frozen while paused).
    task automatic model_step();
        bit fin;
        fin = 1'b0;
        m_done = 1'b0;
        if (stop) begin
            m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_idx = 0;
            m_pos = 0;
        end else if (m_active) begin
            if (m_pos == 0) begin
                m_pos = 1;
            end else if (m_pos == 1) begin
                m_per = int'(tbl_p[m_idx]);
                m_dur = int'(tbl_d[m_idx]);
                if (m_dur == 0) fin = 1'b1;
                else m_pos = 2;
            end else if (!pause) begin
                if (m_pos - 1 == m_dur * UC) begin
                    if (m_idx == SL - 1) fin = 1'b1;
                    else begin
                        m_idx++;
                        m_pos = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
        end
        if (fin) begin
            m_done = 1'b1;
            m_idx = 0;
            m_pos = 0;
            m_active = loop_en;
        end
    endtask

    function automatic bit exp_audio();
        if (!m_active || m_pos < 2 || m_per == 0) return 1'b0;
        return 1'(((m_pos - 2) / m_per) % 2);
    endfunction

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_active = 1'b0;
                m_idx = 0;
                m_pos = 0;
                m_per = 0;
                m_dur = 0;
                m_done = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                chk("busy", 32'(busy), 32'(m_active));
                chk("done", 32'(done), 32'(m_done));
                chk("note_idx", 32'(note_idx), 32'(m_idx));
                chk("rom_addr", 32'(rom_addr), 32'(m_idx));
                chk("audio_out", 32'(audio_out), 32'(exp_audio()));
                chk("aud_sd", 32'(aud_sd), 32'd1);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clock);
        #2;
        stop = 1'b0;
    endtask

    task automatic load_base_table();
        for (int i = 0; i < 16; i++) begin
            tbl_p[i] = 8'd0;
            tbl_d[i] = 3'd0;
        end
        tbl_p[0] = 8'd2; tbl_d[0] = 3'd1;
        tbl_p[1] = 8'd0; tbl_d[1] = 3'd2;
        tbl_p[2] = 8'd3; tbl_d[2] = 3'd1;
    endtask

    initial begin
        int done_at;
        int done_n;
        int d2;
        int ra23;
        int max_addr;
        int idx1_at;
        int ones;
        logic [31:0] aud_v;
        logic b22;
        logic b23;

        load_base_table();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_audio", 32'(audio_out), 32'd0);
        chk("rst_note_idx", 32'(note_idx), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(posedge clock);
        #2;

        // plain play-through
        pulse_start();
        done_at = 0; done_n = 0; aud_v = 32'd0; b22 = 1'b0; b23 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c <= 23) aud_v[c] = audio_out;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (c == 22) b22 = busy;
            if (c == 23) b23 = busy;
        end
        chk("t1_done_cycle", done_at, 32'd23);
        chk("t1_done_count", done_n, 32'd1);
        chk("t1_busy_last_play", 32'(b22), 32'd1);
        chk("t1_busy_after", 32'(b23), 32'd0);
        chk("t1_audio_trace", aud_v, 32'h0040_0060);

        // loop mode
        loop_en = 1'b1;
        pulse_start();
        done_at = 0; d2 = 0; ra23 = -1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clock);
            if (done) begin
                if (done_at == 0) done_at = c;
                else if (d2 == 0) d2 = c;
            end
            if (c == 23) ra23 = int'(rom_addr);
        end
        chk("t2_first_done", done_at, 32'd23);
        chk("t2_loop_period", d2 - done_at, 32'd22);
        chk("t2_rom_addr_wrap", ra23, 32'd0);
        loop_en = 1'b0;
        pulse_stop();
        @(negedge clock);
        chk("t2_stop_busy", 32'(busy), 32'd0);
        chk("t2_stop_audio", 32'(audio_out), 32'd0);

        // early end-of-song marker on entry 1
        tbl_d[1] = 3'd0;
        pulse_start();
        done_at = 0; done_n = 0; max_addr = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
        end
        chk("t3_done_cycle", done_at, 32'd9);
        chk("t3_done_count", done_n, 32'd1);
        chk("t3_max_addr", max_addr, 32'd1);
        tbl_d[1] = 3'd2;

        // pause for 5 cycles mid note 0 while the output is high
        pulse_start();
        idx1_at = 0; ones = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (note_idx == 4'd1 && idx1_at == 0) idx1_at = c;
            if (c >= 5 && c <= 10 && audio_out) ones++;
            pause = (c >= 5 && c < 10);
        end
        pause = 1'b0;
        chk("t4_note1_cycle", idx1_at, 32'd12);
        chk("t4_frozen_audio", ones, 32'd6);
        pulse_stop();

        // stop during entry 1, then restart during entry 2
        pulse_start();
        done_n = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            if (c == 11) begin
                chk("t5_stop_busy", 32'(busy), 32'd0);
                chk("t5_stop_audio", 32'(audio_out), 32'd0);
                stop = 1'b0;
            end
            if (done) done_n++;
            if (c == 10) stop = 1'b1;
        end
        chk("t5_no_done", done_n, 32'd0);
        pulse_start();
        for (int c = 1; c <= 21; c++) begin
            @(negedge clock);
            if (c == 20) begin
                chk("t5_addr_before", 32'(rom_addr), 32'd2);
                start = 1'b1;
            end
            if (c == 21) begin
                chk("t5_restart_addr", 32'(rom_addr), 32'd0);
                chk("t5_restart_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end
        pulse_stop();

        // asynchronous reset mid-note (entry 2, output high)
        pulse_start();
        for (int c = 1; c <= 22; c++) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_audio", 32'(audio_out), 32'd0);
        chk("t6_rst_note_idx", 32'(note_idx), 32'd0);
        chk("t6_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            chk("t6_stay_idle", 32'(busy), 32'd0);
        end

        // randomized control and table contents
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            start = ($urandom_range(0, m_active ? 59 : 7) == 0);
            stop = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            if ($urandom_range(0, 39) == 0) loop_en = ~loop_en;
            if (!m_active && !start && $urandom_range(0, 3) == 0) begin
                int j;
                j = int'($urandom_range(0, SL - 1));
                tbl_p[j] = PW'($urandom_range(0, 4));
                tbl_d[j] = DW'($urandom_range(0, 3));
            end
        end
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        loop_en = 1'b0;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised tone sequencer that plays a song from an external note table (period, duration) and produces a square-wave audio output.
- Adds start/stop/pause control, loop mode, an early end-of-song marker, a song-done pulse and a registered table-fetch handshake.
- Sits between the board-level audio pin (with aud_sd) and a song table module. The table is combinational or 1-cycle registered, indexed by note number.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- UNIT_CYCLES, CLK_HZ/8, clock cycles per duration unit (1/8 s at default).
- SONG_LEN, 48, number of table entries; the entry at index SONG_LEN-1 is the last. Must satisfy 1 <= SONG_LEN <= 2**ADDR_W.
- ADDR_W, 10, table index width.
- PERIOD_W, 20, half-period field width in clock cycles.
- DUR_W, 5, duration field width in units.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins or restarts the song at index 0.
- stop  in  1  1-cycle pulse; aborts playback.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; sampled at song end; when high, the song restarts.
- rom_addr  out  ADDR_W  table index being fetched.
- rom_period  in  PERIOD_W  half-period in cycles; 0 means rest. Valid 1 cycle after rom_addr.
- rom_dur  in  DUR_W  duration in units; 0 is the end-of-song marker. Valid 1 cycle after rom_addr.
- audio_out  out  1  square-wave output.
- aud_sd  out  1  amplifier enable; tied to 1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse on song completion.
- note_idx  out  ADDR_W  index of the current note.

Behaviour:
- Reset values (asynchronous): state=IDLE, audio_out=0, busy=0, done=0, note_idx=0, rom_addr=0, all counters=0.
- Control priority each cycle: stop > start > pause.
- stop in any state: IDLE next cycle, audio_out=0, no done pulse.
- start in any state: note_idx=0, state goes to FETCH.
- IDLE: audio_out=0. Waits for start.
- FETCH (1 cycle): rom_addr=note_idx, then LOAD.
- LOAD (1 cycle): latch rom_period and rom_dur, clear all counters, audio_out=0.
  - If the latched dur is 0, take the END path.
  - Otherwise load dur_cnt=dur and go to PLAY.
- PLAY, cycle with pause=0:
  - Tone: if period != 0, half_cnt increments. When half_cnt==period-1, toggle audio_out and set half_cnt=0. So period=1 toggles every cycle.
  - Rest: if period == 0, audio_out is held at 0.
  - Duration: unit_cnt increments. When unit_cnt==UNIT_CYCLES-1, set unit_cnt=0 and decrement dur_cnt.
  - Note end: when dur_cnt reaches 0, take the END path if note_idx==SONG_LEN-1; otherwise note_idx++ and go to FETCH.
- PLAY, cycle with pause=1: all counters, note_idx and audio_out are frozen. Pause in FETCH or LOAD takes effect from the first PLAY cycle.
- Note timing: each note occupies exactly dur*UNIT_CYCLES PLAY cycles plus 2 overhead cycles (FETCH, LOAD). Tone phase restarts at 0 on every note.
- END path: done=1 for exactly one cycle.
  - loop_en=1: note_idx=0, go to FETCH.
  - loop_en=0: go to IDLE, note_idx=0.
- Widths:
  - unit_cnt is $clog2(UNIT_CYCLES) bits.
  - half_cnt is PERIOD_W bits. Comparisons are unsigned; a half-period of 0 never wraps.
  - note_idx wraps only via the END path and never exceeds SONG_LEN-1.
- start and stop in the same cycle: stop wins.
- start in the same cycle as the END path: start wins and done is suppressed.

Decomposition:
- Package song_pkg:
  - State enum: IDLE, FETCH, LOAD, PLAY.
  - Note half-period constants at 100 MHz: C4=191110, D4=170265, E4=151685, F4=143172, G4=127551, C5=95556, SP=0.
  - Duration constants: EIGHTH=1, QUARTER=2, HALF=4, ONE=8, TWO=16.
- Sub-module tone_gen:
  - Holds half_cnt and the audio_out toggle.
  - Inputs: period, enable (PLAY && !pause), clear (LOAD).
  - Output: audio_out, forced to 0 for period 0.
- The song table remains a separate module.

Test Plan:
- UNIT_CYCLES=4, SONG_LEN=3, table {(period 2, dur 1), (0, 2), (3, 1)}:
  - start -> audio toggles every 2 cycles for 4 cycles, then 0 for 8 cycles, then toggles every 3 cycles for 4 cycles.
  - done pulses once; busy deasserts the next cycle.
- Same table with loop_en=1: after the entry-2 note, done pulses and rom_addr returns to 0 within 1 cycle; playback repeats, with a total period of 22 cycles.
- Table entry 1 has dur=0: after the entry-0 note, done pulses at LOAD; entry 2 is never fetched.
- pause high for 5 cycles mid-note-0: audio_out and note_idx are frozen; the note ends exactly 5 cycles late.
- stop during PLAY of entry 1 -> IDLE next cycle, audio_out=0, no done. A start during PLAY of entry 2 -> rom_addr=0 the next cycle.
- reset asserted asynchronously mid-note: all outputs reach reset values immediately, without waiting for a clock edge; the block stays in IDLE after reset releases until start.
